adc_ad7687: RTL

SPI master reader for the AD7687 16-bit SAR ADC in 3-wire CS mode. The block paces conversions from a sample-period counter and drives CNV. After each conversion it clocks out the 16-bit result on SCLK/MISO and presents it as an AXI-Stream master word. It is the capture-side counterpart of the DAC drive path: same mclk domain (50 MHz), same stream conventions, data flowing toward the fabric.

---
 rtl/adc_ad7687_if.sv | 26 ++
 rtl/adc_ad7687.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_ad7687_if.sv
//------------------------------------------------------------------------------
// adc_ad7687_if
// Purpose : stream handshake between the AD7687 reader and its consumer.
// Signals :
//   m_axis_valid  sample word is presented (driven by the reader)
//   s_axis_ready  consumer accepts the word on this edge
//   m_axis_data   16-bit two's-complement ADC code
// Modports: master (the ADC reader), slave (the downstream consumer)
//------------------------------------------------------------------------------
interface adc_ad7687_if;
   logic        m_axis_valid;
   logic        s_axis_ready;
   logic [15:0] m_axis_data;

   modport master (
      output m_axis_valid,
      output m_axis_data,
      input  s_axis_ready
   );

   modport slave (
      input  m_axis_valid,
      input  m_axis_data,
      output s_axis_ready
   );
endinterface

// File: rtl/adc_ad7687.sv
//------------------------------------------------------------------------------
// adc_ad7687
// Purpose : SPI master reader for the AD7687 16-bit SAR ADC in 3-wire CS mode.
//           A sample-period counter paces conversions; each frame holds CNV
//           high for the conversion time, clocks 16 bits out on SCLK/MISO and
//           presents the word on a valid/ready stream.
// Ports   :
//   mclk         system clock
//   rst          synchronous, active-high reset
//   en           enables sampling (a running frame always completes)
//   cnv          convert start; low doubles as chip select
//   sclk         SPI clock, idle low
//   miso         ADC serial data out
//   axis         stream master (m_axis_valid / s_axis_ready / m_axis_data)
//   overrun      sticky flag: a completed sample was dropped
//   overrun_clr  clears overrun (and the drop counter)
//   overrun_cnt  saturating dropped-sample count
// Optional feature macro: ADC_AD7687_OVERRUN_CNT_EN adds the overrun_cnt
//           port and its counter. Without it the port is absent.
//------------------------------------------------------------------------------
module adc_ad7687 #(
   parameter int MCLK_CYCLES_PER_SAMPLE        = 200,
   parameter int MCLK_CYCLES_PER_SPI_CLK_CYCLE = 4,
   parameter int CONV_CYCLES                   = 112
) (
   input  logic                mclk,
   input  logic                rst,
   input  logic                en,
   output logic                cnv,
   output logic                sclk,
   input  logic                miso,
   adc_ad7687_if.master        axis,
   output logic                overrun,
   input  logic                overrun_clr
`ifdef ADC_AD7687_OVERRUN_CNT_EN
   ,
   output logic [15:0]         overrun_cnt
`endif
);

   localparam int SPI = MCLK_CYCLES_PER_SPI_CLK_CYCLE;
   localparam int PW  = (MCLK_CYCLES_PER_SAMPLE > 1) ? $clog2(MCLK_CYCLES_PER_SAMPLE) : 1;
   localparam int CW  = $clog2(CONV_CYCLES + 1);
   localparam int SW  = (SPI > 1) ? $clog2(SPI) : 1;

   // Parameter sanity: the frame must fit inside one sample period.
   generate
      if (!(CONV_CYCLES + 16 * SPI + 2 < MCLK_CYCLES_PER_SAMPLE)) begin : g_bad_period
         $error("adc_ad7687: CONV_CYCLES + 16*SPI + 2 must be below MCLK_CYCLES_PER_SAMPLE");
      end
      if ((SPI < 2) || ((SPI % 2) != 0)) begin : g_bad_spi
         $error("adc_ad7687: MCLK_CYCLES_PER_SPI_CLK_CYCLE must be even and at least 2");
      end
   endgenerate

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_CONV = 3'd1,
      ST_GAP  = 3'd2,
      ST_XFER = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   state_t       r_state;
   state_t       w_state_nxt;
   logic [PW-1:0] r_period;
   logic [CW-1:0] r_conv_cnt;
   logic [SW-1:0] r_phase;
   logic [4:0]    r_bit_cnt;
   logic [15:0]   r_shift;
   logic          r_valid;
   logic [15:0]   r_data;
   logic          r_overrun;

   logic w_frame_start;
   logic w_conv_last;
   logic w_phase_last;
   logic w_capture;
   logic w_handshake;
   logic w_load;
   logic w_drop;

   assign w_frame_start = (r_state == ST_IDLE) && en && (r_period == PW'(0));
   assign w_conv_last   = (r_conv_cnt == CW'(CONV_CYCLES - 1));
   assign w_phase_last  = (r_phase == SW'(SPI - 1));
   // Sample MISO one mclk after the SCLK rise, well before the fall.
   assign w_capture     = (r_state == ST_XFER) && (r_phase == SW'(0));
   assign w_handshake   = r_valid && axis.s_axis_ready;
   assign w_load        = (r_state == ST_DONE) && (!r_valid || w_handshake);
   assign w_drop        = (r_state == ST_DONE) && r_valid && !axis.s_axis_ready;

   // Sample-period counter, held at zero while sampling is disabled.
   always_ff @(posedge mclk) begin
      if (rst) begin
         r_period <= PW'(0);
      end else if (!en) begin
         r_period <= PW'(0);
      end else if (r_period == PW'(MCLK_CYCLES_PER_SAMPLE - 1)) begin
         r_period <= PW'(0);
      end else begin
         r_period <= r_period + PW'(1);
      end
   end

   // Frame state register.
   always_ff @(posedge mclk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Frame next-state decode.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_frame_start) begin
               w_state_nxt = ST_CONV;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_CONV: begin
            if (w_conv_last) begin
               w_state_nxt = ST_GAP;
            end else begin
               w_state_nxt = ST_CONV;
            end
         end
         ST_GAP: begin
            w_state_nxt = ST_XFER;
         end
         ST_XFER: begin
            if (w_phase_last && (r_bit_cnt == 5'd16)) begin
               w_state_nxt = ST_DONE;
            end else begin
               w_state_nxt = ST_XFER;
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Conversion-time counter, running only while CNV is high.
   always_ff @(posedge mclk) begin
      if (rst) begin
         r_conv_cnt <= CW'(0);
      end else if ((r_state == ST_CONV) && !w_conv_last) begin
         r_conv_cnt <= r_conv_cnt + CW'(1);
      end else begin
         r_conv_cnt <= CW'(0);
      end
   end

   // SCLK phase counter within each SPI period.
   always_ff @(posedge mclk) begin
      if (rst) begin
         r_phase <= SW'(0);
      end else if ((r_state == ST_XFER) && !w_phase_last) begin
         r_phase <= r_phase + SW'(1);
      end else begin
         r_phase <= SW'(0);
      end
   end

   // Captured-bit counter; cleared outside the transfer.
   always_ff @(posedge mclk) begin
      if (rst) begin
         r_bit_cnt <= 5'd0;
      end else if (r_state != ST_XFER) begin
         r_bit_cnt <= 5'd0;
      end else if (w_capture) begin
         r_bit_cnt <= r_bit_cnt + 5'd1;
      end else begin
         r_bit_cnt <= r_bit_cnt;
      end
   end

   // MSB-first shift register; reset discards any partial sample.
   always_ff @(posedge mclk) begin
      if (rst) begin
         r_shift <= 16'd0;
      end else if (w_capture) begin
         r_shift <= {r_shift[14:0], miso};
      end else begin
         r_shift <= r_shift;
      end
   end

   // Output word and valid: a load in DONE wins over the handshake clear.
   always_ff @(posedge mclk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_data  <= 16'd0;
      end else if (w_load) begin
         r_valid <= 1'b1;
         r_data  <= r_shift;
      end else if (w_handshake) begin
         r_valid <= 1'b0;
         r_data  <= r_data;
      end else begin
         r_valid <= r_valid;
         r_data  <= r_data;
      end
   end

   // Sticky overrun flag; a drop beats a simultaneous clear.
   always_ff @(posedge mclk) begin
      if (rst) begin
         r_overrun <= 1'b0;
      end else if (w_drop) begin
         r_overrun <= 1'b1;
      end else if (overrun_clr) begin
         r_overrun <= 1'b0;
      end else begin
         r_overrun <= r_overrun;
      end
   end

`ifdef ADC_AD7687_OVERRUN_CNT_EN
   logic [15:0] r_overrun_cnt;

   // Saturating drop counter; a drop during clear restarts it at one.
   always_ff @(posedge mclk) begin
      if (rst) begin
         r_overrun_cnt <= 16'd0;
      end else if (w_drop && overrun_clr) begin
         r_overrun_cnt <= 16'd1;
      end else if (w_drop) begin
         if (r_overrun_cnt != 16'hFFFF) begin
            r_overrun_cnt <= r_overrun_cnt + 16'd1;
         end else begin
            r_overrun_cnt <= r_overrun_cnt;
         end
      end else if (overrun_clr) begin
         r_overrun_cnt <= 16'd0;
      end else begin
         r_overrun_cnt <= r_overrun_cnt;
      end
   end

   assign overrun_cnt = r_overrun_cnt;
`endif

   // CNV and SCLK decode straight from registers, so they cannot glitch.
   assign cnv               = (r_state == ST_CONV);
   assign sclk              = (r_state == ST_XFER) && (r_phase < SW'(SPI / 2));
   assign axis.m_axis_valid = r_valid;
   assign axis.m_axis_data  = r_data;
   assign overrun           = r_overrun;

endmodule
